// File: rtl/dmem_responder.sv
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM stage of the pipelined
// processor. Holds a word-addressed store of 2^ADDR_WIDTH 32-bit words and
// serves one load/store at a time with a fixed LATENCY. While an access is in
// flight `stall` is high so the processor freezes its pipeline and keeps the
// request stable.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   mem_read    load request
//   mem_write   store request (both high: store wins, load sees old word)
//   address     byte address; word index is address[ADDR_WIDTH+1:2]
//   write_data  store data
//   read_data   registered load data, held until the next load commit
//   stall       combinational hold request to the pipeline
//   done        one-cycle pulse in the cycle an access completes
//   misaligned  one-cycle pulse the cycle after a misaligned request
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRespond
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  rd_q, wr_q;
  logic                  latch;
  logic                  misaligned_q;

  logic [31:0] store [Depth];

  // Request decode
  logic                  req_any;
  logic                  aligned;
  logic                  req;
  logic [ADDR_WIDTH-1:0] in_idx;

  assign req_any = mem_read | mem_write;
  assign aligned = (address[1:0] == 2'b00);
  assign req     = req_any & aligned;
  assign in_idx  = address[ADDR_WIDTH+1:2];

  // Upper address bits are ignored so addresses wrap around the store.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

  // Next-state / output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          latch   = 1'b1;
          stall   = 1'b1;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StRespond : StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d = StRespond;
        end
      end
      StRespond: begin
        // The request is still present here; it must not be accepted again.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  assign done       = (state_q == StRespond);
  assign misaligned = misaligned_q;

  // Commit happens on the edge entering RESPOND. With LATENCY=1 that edge is
  // the acceptance edge, so the inputs are used directly instead of the
  // latched copies.
  logic                  commit;
  logic                  from_idle;
  logic [ADDR_WIDTH-1:0] commit_idx;
  logic [31:0]           commit_wdata;
  logic                  commit_rd;
  logic                  commit_wr;

  assign commit       = (state_d == StRespond) && (state_q != StRespond);
  assign from_idle    = (state_q == StIdle);
  assign commit_idx   = from_idle ? in_idx     : idx_q;
  assign commit_wdata = from_idle ? write_data : wdata_q;
  assign commit_rd    = from_idle ? mem_read   : rd_q;
  assign commit_wr    = from_idle ? mem_write  : wr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      read_data    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= from_idle & req_any & ~aligned;
      if (latch) begin
        idx_q   <= in_idx;
        wdata_q <= write_data;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
      // Non-blocking read of the store gives read-before-write when both
      // operations commit on the same edge.
      if (commit && commit_rd) begin
        read_data <= store[commit_idx];
      end
    end
  end

  // Store contents are not reset; the reset guard only blocks a write from
  // landing on an edge where reset is already asserted.
  always_ff @(posedge clk) begin
    if (!reset && commit && commit_wr) begin
      store[commit_idx] <= commit_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned NW  = 1 << AW;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        misaligned;

  int total;
  int bad;
  int cycle;

  dmem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .stall     (stall),
    .done      (done),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: plain word array with validity, indexed by byte address / 4 mod depth.
  logic [31:0] model_mem [NW];
  bit          model_vld [NW];
  logic [31:0] last_rd;

  task automatic model_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] exp, output bit expv);
    int unsigned i;
    i    = (addr / 4) % NW;
    exp  = model_mem[i];
    expv = model_vld[i];
    if (wr) begin
      model_mem[i] = wd;
      model_vld[i] = 1'b1;
    end
    if (rd) last_rd = exp;
  endtask

  // Drives one request from just after a rising edge and measures it until done.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, output int stalls, output int done_cyc,
                            output logic [31:0] rdv, output logic stall_at_done,
                            output int done_at);
    mem_read      = rd;
    mem_write     = wr;
    address       = addr;
    write_data    = wd;
    stalls        = 0;
    done_cyc      = -1;
    rdv           = '0;
    stall_at_done = 1'b0;
    done_at       = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc      = c;
        rdv           = read_data;
        stall_at_done = stall;
        done_at       = cycle;
      end else if (stall) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    int stalls, dc, da;
    logic [31:0] rdv, exp;
    logic sd;
    bit expv;
    reset     = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    address   = 32'h0;
    write_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (stall !== 1'b0) begin
        bad++; $display("FAIL reset_stall: got %b want 0", stall);
      end
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL reset_done: got %b want 0", done);
      end
      total++;
      if (read_data !== 32'h0) begin
        bad++; $display("FAIL reset_read_data: got %h want 0", read_data);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_rd = 32'h0;
    model_op(1'b1, 1'b0, 32'h0, 32'h0, exp, expv);
    run_access(1'b1, 1'b0, 32'h0, 32'h0, stalls, dc, rdv, sd, da);
    total++;
    if (stalls !== LAT) begin
      bad++; $display("FAIL reset_first_load_stalls: got %0d want %0d", stalls, LAT);
    end
    total++;
    if (dc !== LAT) begin
      bad++; $display("FAIL reset_first_load_done: got cycle %0d want %0d", dc, LAT);
    end
  endtask

  task automatic test_store_load();
    int stalls, dc, da;
    logic [31:0] rdv, exp;
    logic sd;
    bit expv;
    model_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, exp, expv);
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, stalls, dc, rdv, sd, da);
    total++;
    if (stalls !== LAT) begin
      bad++; $display("FAIL store_stalls: got %0d want %0d", stalls, LAT);
    end
    total++;
    if (dc !== LAT) begin
      bad++; $display("FAIL store_done: got cycle %0d want %0d", dc, LAT);
    end
    total++;
    if (sd !== 1'b0) begin
      bad++; $display("FAIL store_stall_at_done: got %b want 0", sd);
    end
    model_op(1'b1, 1'b0, 32'h10, 32'h0, exp, expv);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, stalls, dc, rdv, sd, da);
    total++;
    if (stalls !== LAT) begin
      bad++; $display("FAIL load_stalls: got %0d want %0d", stalls, LAT);
    end
    total++;
    if (dc !== LAT) begin
      bad++; $display("FAIL load_done: got cycle %0d want %0d", dc, LAT);
    end
    total++;
    if (rdv !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_data: got %h want %h", rdv, 32'hDEADBEEF);
    end
    // Request was held through the RESPOND cycle; it must not have been re-accepted.
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL no_reaccept: got stall=%b done=%b want 0 0", stall, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int stalls, dc, da0, da1;
    logic [31:0] rdv0, rdv1, exp0, exp1, e;
    logic sd;
    bit expv;
    model_op(1'b0, 1'b1, 32'h04, 32'h11111111, e, expv);
    run_access(1'b0, 1'b1, 32'h04, 32'h11111111, stalls, dc, rdv0, sd, da0);
    model_op(1'b0, 1'b1, 32'h08, 32'h22222222, e, expv);
    run_access(1'b0, 1'b1, 32'h08, 32'h22222222, stalls, dc, rdv0, sd, da0);
    model_op(1'b1, 1'b0, 32'h04, 32'h0, exp0, expv);
    run_access(1'b1, 1'b0, 32'h04, 32'h0, stalls, dc, rdv0, sd, da0);
    model_op(1'b1, 1'b0, 32'h08, 32'h0, exp1, expv);
    run_access(1'b1, 1'b0, 32'h08, 32'h0, stalls, dc, rdv1, sd, da1);
    total++;
    if (rdv0 !== exp0) begin
      bad++; $display("FAIL b2b_first_data: got %h want %h", rdv0, exp0);
    end
    total++;
    if (rdv1 !== exp1) begin
      bad++; $display("FAIL b2b_second_data: got %h want %h", rdv1, exp1);
    end
    total++;
    if (da1 - da0 !== LAT + 1) begin
      bad++; $display("FAIL b2b_spacing: got %0d want %0d", da1 - da0, LAT + 1);
    end
  endtask

  task automatic test_misaligned();
    int stalls, dc, da;
    logic [31:0] rdv, exp, held;
    logic sd;
    bit expv;
    held       = last_rd;
    mem_write  = 1'b1;
    address    = 32'h0000_0012;
    write_data = 32'h77777777;
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || misaligned !== 1'b0) begin
      bad++; $display("FAIL mis_cycle0: got stall=%b mis=%b want 0 0", stall, misaligned);
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || misaligned !== 1'b1) begin
      bad++; $display("FAIL mis_cycle1: got stall=%b mis=%b want 0 1", stall, misaligned);
    end
    total++;
    if (read_data !== held) begin
      bad++; $display("FAIL mis_read_data_held: got %h want %h", read_data, held);
    end
    @(negedge clk);
    total++;
    if (misaligned !== 1'b0) begin
      bad++; $display("FAIL mis_single_pulse: got %b want 0", misaligned);
    end
    @(posedge clk);
    #1;
    model_op(1'b1, 1'b0, 32'h10, 32'h0, exp, expv);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, stalls, dc, rdv, sd, da);
    total++;
    if (rdv !== exp) begin
      bad++; $display("FAIL mis_no_write: got %h want %h", rdv, exp);
    end
  endtask

  task automatic test_reset_mid_write();
    int stalls, dc, da;
    logic [31:0] rdv, exp;
    logic sd;
    bit expv;
    bit saw_done;
    model_op(1'b0, 1'b1, 32'h20, 32'h0, exp, expv);
    run_access(1'b0, 1'b1, 32'h20, 32'h0, stalls, dc, rdv, sd, da);
    mem_write  = 1'b1;
    address    = 32'h20;
    write_data = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL rmw_in_wait: got stall=%b want 1", stall);
    end
    reset = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || read_data !== 32'h0) begin
      bad++; $display("FAIL rmw_reset_outputs: got stall=%b rd=%h want 0 0", stall, read_data);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++; $display("FAIL rmw_no_done: got done pulse want none");
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    reset     = 1'b0;
    last_rd   = 32'h0;
    model_op(1'b1, 1'b0, 32'h20, 32'h0, exp, expv);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, stalls, dc, rdv, sd, da);
    total++;
    if (rdv !== 32'h0) begin
      bad++; $display("FAIL rmw_aborted_write: got %h want 0", rdv);
    end
  endtask

  task automatic test_both_wrap();
    int stalls, dc, da;
    logic [31:0] rdv, exp;
    logic sd;
    bit expv;
    model_op(1'b0, 1'b1, 32'h0, 32'h1, exp, expv);
    run_access(1'b0, 1'b1, 32'h0, 32'h1, stalls, dc, rdv, sd, da);
    model_op(1'b1, 1'b1, 32'h400, 32'h5A5A5A5A, exp, expv);
    run_access(1'b1, 1'b1, 32'h400, 32'h5A5A5A5A, stalls, dc, rdv, sd, da);
    total++;
    if (rdv !== 32'h1) begin
      bad++; $display("FAIL both_read_before_write: got %h want %h", rdv, 32'h1);
    end
    total++;
    if (stalls !== LAT) begin
      bad++; $display("FAIL both_stalls: got %0d want %0d", stalls, LAT);
    end
    model_op(1'b1, 1'b0, 32'h0, 32'h0, exp, expv);
    run_access(1'b1, 1'b0, 32'h0, 32'h0, stalls, dc, rdv, sd, da);
    total++;
    if (rdv !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL wrap_write: got %h want %h", rdv, 32'h5A5A5A5A);
    end
  endtask

  task automatic test_random();
    int stalls, dc, da;
    logic [31:0] rdv, exp, addr, wd;
    logic sd, rd, wr;
    bit expv;
    int unsigned op;
    for (int n = 0; n < 40; n++) begin
      op   = $urandom_range(0, 5);
      addr = $urandom;
      wd   = $urandom;
      if (op == 0) begin
        if (addr[1:0] == 2'b00) addr[0] = 1'b1;
        mem_read   = $urandom_range(0, 1) == 1;
        mem_write  = ~mem_read;
        address    = addr;
        write_data = wd;
        @(negedge clk);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        total++;
        if (misaligned !== 1'b1 || stall !== 1'b0) begin
          bad++; $display("FAIL rand_mis %0d: got mis=%b stall=%b want 1 0", n, misaligned, stall);
        end
        @(posedge clk);
        #1;
      end else begin
        addr[1:0] = 2'b00;
        rd = (op != 2);
        wr = (op == 2) || (op == 3) || (op == 5);
        model_op(rd, wr, addr, wd, exp, expv);
        run_access(rd, wr, addr, wd, stalls, dc, rdv, sd, da);
        total++;
        if (stalls !== LAT || dc !== LAT) begin
          bad++; $display("FAIL rand_timing %0d: got stalls=%0d done=%0d want %0d %0d",
                          n, stalls, dc, LAT, LAT);
        end
        if (rd && expv) begin
          total++;
          if (rdv !== exp) begin
            bad++; $display("FAIL rand_data %0d addr=%h: got %h want %h", n, addr, rdv, exp);
          end
        end
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    last_rd    = 32'h0;
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_write();
    test_both_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
